// File: rtl/conv_inst_arb_if.sv
// Request and issue bundle between conv instruction sources, the arbiter and the loop expander.
// slave = arbiter view, master = environment (sources plus expander) view.
interface conv_inst_arb_if #(
    parameter int IW   = 40,
    parameter int NREQ = 4,
    parameter int SW   = 2
);
    logic [NREQ*IW-1:0] req_inst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [IW-1:0]      s_inst;
    logic               s_valid;
    logic               s_ready;
    logic [SW-1:0]      s_src;
    logic               locked;

    modport slave (
        input  req_inst, req_valid, s_ready,
        output req_ready, s_inst, s_valid, s_src, locked
    );

    modport master (
        output req_inst, req_valid, s_ready,
        input  req_ready, s_inst, s_valid, s_src, locked
    );
endinterface

// File: rtl/conv_inst_arb.sv
// Round-robin arbiter with grant lock sharing one conv loop expander; CONV_INST_ARB_STAT_EN adds per-source accept counters.
// Latency: one cycle from accept edge to s_valid; full throughput under continuous s_ready.
// Backpressure: while s_valid && !s_ready the output holds and every req_ready is low.
module conv_inst_arb #(
    parameter int IW       = 40,
    parameter int NREQ     = 4,
    parameter int SW       = 2,
    parameter int LOCK_MAX = 16,
    parameter int CW       = 16
) (
    input  logic clk,
    input  logic rst,
    conv_inst_arb_if.slave bus
`ifdef CONV_INST_ARB_STAT_EN
    ,
    input  logic               stat_clr,
    output logic [NREQ*CW-1:0] stat_cnt
`endif
);
    localparam int LCW = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;

    if (((1 << SW) < NREQ) || (NREQ < 2) || (NREQ > 8) || (LOCK_MAX < 2) || (CW < 1)) begin : g_bad_param
        $error("conv_inst_arb: illegal parameter combination");
    end

    typedef enum logic {ST_FREE, ST_LOCK} state_t;

    state_t          state, state_nxt;
    logic [SW-1:0]   ptr;
    logic [SW-1:0]   lock_id;
    logic [LCW-1:0]  lock_cnt;
    logic [SW-1:0]   win;
    logic            win_vld;
    logic [IW-1:0]   win_inst;
    logic            lock_bit;
    logic            ld;
    logic            acc;
    logic            tmo;
    logic [2*NREQ-1:0] vld_rot;

    assign ld       = !bus.s_valid || bus.s_ready;
    assign acc      = ld && win_vld;
    assign win_inst = bus.req_inst[int'(win)*IW +: IW];
    assign lock_bit = win_inst[IW-1];
    assign tmo      = (state == ST_LOCK) && (lock_cnt == LCW'(LOCK_MAX-1));
    assign vld_rot  = {bus.req_valid, bus.req_valid} >> ptr;

    // Rotated search: the lowest set bit of vld_rot is the first valid at or after ptr.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        if (state == ST_LOCK) begin
            win     = lock_id;
            win_vld = bus.req_valid[lock_id];
        end else begin
            for (int k = NREQ-1; k >= 0; k--) begin
                if (vld_rot[k]) begin
                    win_vld = 1'b1;
                    win     = (int'(ptr) + k >= NREQ) ? SW'(int'(ptr) + k - NREQ)
                                                      : SW'(int'(ptr) + k);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_FREE;
        else     state <= state_nxt;
    end

    // Timeout wins over everything, and a lock bit seen in the release cycle cannot relock.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_FREE: if (acc && lock_bit)                 state_nxt = ST_LOCK;
            ST_LOCK: if (tmo || (acc && !lock_bit))       state_nxt = ST_FREE;
            default:                                      state_nxt = ST_FREE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        if (acc) bus.req_ready[win] = 1'b1;
        bus.locked = (state == ST_LOCK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.s_valid <= 1'b0;
            bus.s_inst  <= '0;
            bus.s_src   <= '0;
            ptr         <= '0;
            lock_id     <= '0;
            lock_cnt    <= '0;
        end else begin
            if (ld) bus.s_valid <= acc;
            if (acc) begin
                bus.s_inst <= win_inst;
                bus.s_src  <= win;
            end
            if (acc && state == ST_FREE)
                ptr <= (win == SW'(NREQ-1)) ? '0 : win + SW'(1);
            if (acc && state == ST_FREE && lock_bit) begin
                lock_id  <= win;
                lock_cnt <= '0;
            end else if (state == ST_LOCK) begin
                lock_cnt <= lock_cnt + LCW'(1);
            end
        end
    end

`ifdef CONV_INST_ARB_STAT_EN
    for (genvar i = 0; i < NREQ; i++) begin : g_stat
        logic [CW-1:0] cnt;
        always_ff @(posedge clk) begin
            if (rst || stat_clr)
                cnt <= '0;
            else if (acc && win == SW'(i) && cnt != '1)
                cnt <= cnt + CW'(1);
        end
        assign stat_cnt[i*CW +: CW] = cnt;
    end
`endif
endmodule

// File: doc/conv_inst_arb.md
Name: conv_inst_arb

Overview:
- Round-robin arbiter that shares one conv instruction-loop expander between NREQ instruction sources (host queue, prefetch, debug, ...).
- Each source offers 40-bit conv instructions on a valid/ready port. The arbiter issues one instruction per cycle to the expander's m_inst/m_valid/m_ready input through a registered output stage.
- A source may lock the grant for back-to-back instructions. The lock is released by the source or forcibly after a bounded time.

Parameters:
- IW, 40, instruction width; bit 39 is the LOCK flag, bits [38:0] are opaque.
- NREQ, 4, number of requesters (2..8).
- SW, 2, source-id width; must satisfy 2^SW >= NREQ.
- LOCK_MAX, 16, maximum cycles a lock may persist (>= 2).
- CW, 16, statistics counter width (used only with the optional feature).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_inst  in  NREQ*IW  requester instructions; requester i occupies [i*IW +: IW].
- req_valid  in  NREQ  per-requester valid.
- req_ready  out  NREQ  per-requester ready; at most one bit high per cycle.
- s_inst  out  IW  issued instruction, to the expander's m_inst.
- s_valid  out  1  issued instruction valid, to the expander's m_valid.
- s_ready  in  1  expander ready, from the expander's m_ready.
- s_src  out  SW  index of the requester that produced s_inst.
- locked  out  1  lock currently held.

Behaviour:
- Reset values (rst sampled high at the clock edge):
  - s_valid = 0, s_inst = 0, s_src = 0, req_ready = 0.
  - Round-robin pointer ptr = 0, locked = 0, lock_id = 0, lock_cnt = 0.
  - Reset mid-operation discards any held instruction with no handshake.
- Load enable: ld = !s_valid || s_ready. This gives full throughput, one instruction per cycle under continuous s_ready.
- Winner selection (combinational):
  - Unlocked: first i with req_valid[i] = 1, searching ptr, ptr+1, ..., wrapping mod NREQ.
  - Locked: winner = lock_id only if req_valid[lock_id]; otherwise no winner. Other requesters are not served while locked.
- Handshake:
  - req_ready[winner] = ld && winner exists; all other bits 0.
  - Ready never depends on a requester's own valid, other than through the search.
  - Accept at an edge where req_valid & req_ready. On accept: s_inst <= req_inst[winner], s_src <= winner, s_valid <= 1.
  - If ld is true and there is no winner: s_valid <= 0.
  - If !ld: output registers hold, stable until s_ready.
- Latency: one cycle, accept edge to s_valid high. s_inst must not change while s_valid && !s_ready.
- Pointer: on an unlocked accept, ptr <= (winner+1) mod NREQ. While locked, ptr holds.
- Lock set (accept while unlocked and accepted bit 39 = 1):
  - locked <= 1, lock_id <= winner, lock_cnt <= 0.
  - ptr still advances, so the next fair slot is preserved.
- Lock release by the requester: locked-state accept with bit 39 = 0 gives locked <= 0. That instruction is still issued.
- Lock hold: a locked-state accept with bit 39 = 1 keeps the lock.
- Lock timeout:
  - While locked, lock_cnt increments every cycle, granted or idle.
  - In the cycle where lock_cnt == LOCK_MAX-1: locked <= 0 at the edge, regardless of any accept that cycle. An accept in that cycle is still issued.
  - The lock cannot be re-asserted by an instruction accepted in the release cycle. After release, normal RR resumes from ptr.
- Simultaneous events: a release by bit 39 = 0 and a timeout in the same cycle produce one release, with no double action.
- Bit 39 passes through unchanged to s_inst.

Optional Feature:
- Macro: CONV_INST_ARB_STAT_EN.
- Defined: adds ports stat_clr (in, 1) and stat_cnt (out, NREQ*CW).
  - Counter i increments on each accept from requester i; saturating at all-ones, no wrap.
  - stat_clr = 1 zeroes all counters at the edge and takes priority over an increment the same cycle.
  - rst zeroes all counters.
- Not defined: ports and counters are absent; remaining behaviour identical.

Test Plan:
- Reset, then all four req_valid high with LOCK = 0 and s_ready = 1 -> grants in order 0,1,2,3,0,... one per cycle; s_src matches; s_valid first high one cycle after the first accept.
- Requester 2 holds one instruction, address field [21:8] = 14'h2000, loop field [28:22] = 6; s_ready low for 20 cycles -> s_inst stable, all req_ready = 0, no loss or duplication; the instruction issues exactly once after s_ready rises.
- Requester 1 sends 3 instructions with LOCK = 1,1,0 while requesters 0 and 3 are valid -> s_src = 1,1,1 consecutively, locked high for the duration, then RR resumes at 2 (requester 3 next).
- Requester 0 sets LOCK = 1, then drops valid; LOCK_MAX = 16 -> locked clears exactly 16 cycles after the lock edge; requester 1 is granted on the following cycle.
- Assert rst while s_valid = 1 and locked = 1 -> next cycle s_valid = 0, locked = 0, ptr = 0; the first grant after reset goes to the lowest valid index.
- With CONV_INST_ARB_STAT_EN, CW = 4: 20 accepts from requester 3 -> stat_cnt[3] = 15, saturated; stat_clr pulse -> all counters 0.
